// File: rtl/gpu_queue_arbiter.sv
// Round-robin arbiter draining NUM_SRC registered-output command queues into one valid/ready stream.
// Optional build macro GPU_ARB_PRIORITY_EN gives source 0 strict priority over the rotation.
module gpu_queue_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int WIDTH   = 32,
    parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_empty,
    output logic [NUM_SRC-1:0]       src_pop,
    input  logic [NUM_SRC-1:0]       src_mask,
    output logic [WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(NUM_SRC - 1);

    logic [1:0]       r_state;
    logic [SRC_W-1:0] r_last;
    logic [SRC_W-1:0] r_gsel;
    logic [WIDTH-1:0] r_out_data;
    logic [SRC_W-1:0] r_out_src;
    logic             r_out_valid;

    logic [NUM_SRC-1:0] w_elig;
    logic [SRC_W-1:0]   w_pick;
    logic               w_found;
    logic               w_keep_last;
    logic               w_issue;
    logic               w_grant;
    logic [WIDTH-1:0]   w_words [NUM_SRC];
    logic [WIDTH-1:0]   w_src_word;

    assign w_elig = ~src_empty & src_mask;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_word
            assign w_words[g] = src_data[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_src_word = w_words[r_gsel];

    // Search starts one past the last grant and wraps modulo NUM_SRC, not 2^SRC_W.
    always_comb begin
        int unsigned v_idx;
        v_idx       = 0;
        w_pick      = '0;
        w_found     = 1'b0;
        w_keep_last = 1'b0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            v_idx = (32'(r_last) + k) % NUM_SRC;
            if (!w_found && w_elig[v_idx[SRC_W-1:0]]) begin
                w_pick  = v_idx[SRC_W-1:0];
                w_found = 1'b1;
            end
        end
`ifdef GPU_ARB_PRIORITY_EN
        // Source 0 pre-empts the rotation without advancing it.
        if (w_elig[0]) begin
            w_pick      = '0;
            w_found     = 1'b1;
            w_keep_last = 1'b1;
        end
`else
        w_keep_last = 1'b0;
`endif
    end

    assign w_issue = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
    assign w_grant = w_issue && w_found;

    always_comb begin
        src_pop = '0;
        if (rstn && w_grant) begin
            src_pop[w_pick] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_last      <= LAST_INIT;
            r_gsel      <= '0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_gsel  <= w_pick;
                        if (!w_keep_last) begin
                            r_last <= w_pick;
                        end
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_out_data  <= w_src_word;
                    r_out_src   <= r_gsel;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_grant) begin
                            r_gsel  <= w_pick;
                            if (!w_keep_last) begin
                                r_last <= w_pick;
                            end
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule
